// File: rtl/pkt_proc_ctrl.sv
// rtl/pkt_proc_ctrl.sv - packet processor control FSM (optional run watchdog: PKT_PROC_CTRL_TIMEOUT_EN)
module pkt_proc_ctrl #(
    parameter int IMEM_AW = 9,
    parameter int TMO_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pkt_wr,
    input  logic               pkt_last,
    input  logic               fifo_full,
    output logic               rx_rdy,
    input  logic               cmd_wr,
    input  logic [31:0]        cmd_data,
    input  logic               cmd_go,
    input  logic               cmd_clr,
    input  logic               sw_reload,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_data,
    input  logic               proc_done,
    input  logic               tx_done,
    input  logic [TMO_W-1:0]   timeout_cfg,
    output logic [1:0]         mode_code,
    output logic               pipe_rst,
    output logic [31:0]        status
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        LOAD  = 3'd2,
        PRIME = 3'd3,
        RUN   = 3'd4,
        SEND  = 3'd5,
        ERR   = 3'd6
    } state_t;

    state_t state, next_state;

    // Extra top bit marks that every instruction address has been written.
    logic [IMEM_AW:0] load_cnt;
    logic [15:0]      pkt_cnt;
    logic             prog_valid;
    logic             load_ovf;
    logic             cmd_drop;
    logic             tmo_flag;
    logic             accept;
    logic             run_expired;
    logic             load_wr;
    logic [8:0]       load_cnt9;

    assign accept    = (state == RECV) && pkt_wr && !fifo_full;
    assign load_wr   = (state == LOAD) && cmd_wr && !load_cnt[IMEM_AW];
    assign load_cnt9 = 9'(load_cnt);

`ifdef PKT_PROC_CTRL_TIMEOUT_EN
    logic [TMO_W-1:0] run_cnt;

    // Watchdog counts RUN cycles, restarting from 0 on every RUN entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            run_cnt <= '0;
        else if (state == RUN)
            run_cnt <= run_cnt + 1'b1;
        else
            run_cnt <= '0;
    end

    assign run_expired = (state == RUN) && (timeout_cfg != '0) &&
                         (run_cnt == timeout_cfg - TMO_W'(1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^timeout_cfg;
    assign run_expired        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state selection; proc_done takes priority over watchdog expiry.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = RECV;
            RECV:  if (accept && pkt_last)
                       next_state = (!prog_valid || sw_reload) ? LOAD : PRIME;
            LOAD:  if (cmd_go) next_state = PRIME;
            PRIME: next_state = RUN;
            RUN:   if (proc_done) next_state = SEND;
                   else if (run_expired) next_state = ERR;
            SEND:  if (tx_done) next_state = RECV;
            ERR:   if (cmd_clr) next_state = RECV;
            default: next_state = IDLE;
        endcase
    end

    // Mode, pipeline reset and RX handshake decoded from the current state.
    always_comb begin
        mode_code = 2'b00;
        pipe_rst  = 1'b1;
        rx_rdy    = 1'b0;
        case (state)
            RECV:  begin pipe_rst = 1'b0; rx_rdy = !fifo_full; end
            LOAD:  mode_code = 2'b10;
            PRIME: mode_code = 2'b10;
            RUN:   begin mode_code = 2'b10; pipe_rst = 1'b0; end
            SEND:  begin mode_code = 2'b01; pipe_rst = 1'b0; end
            default: ;
        endcase
    end

    // Instruction-memory write port and load counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_data <= '0;
            load_cnt  <= '0;
        end else begin
            imem_we <= load_wr;
            if (load_wr) begin
                imem_addr <= load_cnt[IMEM_AW-1:0];
                imem_data <= cmd_data;
                load_cnt  <= load_cnt + 1'b1;
            end else if (state == RECV && next_state == LOAD) begin
                load_cnt  <= '0;
            end
        end
    end

    // Program-valid, sticky error flags and packet counter; new events beat cmd_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prog_valid <= 1'b0;
            load_ovf   <= 1'b0;
            cmd_drop   <= 1'b0;
            tmo_flag   <= 1'b0;
            pkt_cnt    <= '0;
        end else begin
            if (state == LOAD && cmd_go)
                prog_valid <= 1'b1;
            else if (state == ERR && cmd_clr)
                prog_valid <= 1'b0;
            if (cmd_clr) begin
                load_ovf <= 1'b0;
                cmd_drop <= 1'b0;
                tmo_flag <= 1'b0;
            end
            if (state == LOAD && cmd_wr && load_cnt[IMEM_AW])
                load_ovf <= 1'b1;
            if (state != LOAD && cmd_wr)
                cmd_drop <= 1'b1;
            if (run_expired && !proc_done)
                tmo_flag <= 1'b1;
            if (state == SEND && tx_done)
                pkt_cnt <= pkt_cnt + 1'b1;
        end
    end

    assign status = {pkt_cnt, load_cnt9, tmo_flag, cmd_drop, load_ovf, prog_valid, state};

endmodule

// File: tb/tb_pkt_proc_ctrl.sv
// tb/tb_pkt_proc_ctrl.sv - scoreboard bench for pkt_proc_ctrl (default and IMEM_AW=2 instances)
module tb_pkt_proc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        pkt_wr, pkt_last, fifo_full, cmd_wr, cmd_go, cmd_clr, sw_reload;
    logic        proc_done, tx_done;
    logic [31:0] cmd_data;
    logic [15:0] timeout_cfg;

    logic        rx_rdy0, imem_we0, pipe_rst0;
    logic [8:0]  imem_addr0;
    logic [31:0] imem_data0, status0;
    logic [1:0]  mode0;

    logic        rx_rdy1, imem_we1, pipe_rst1;
    logic [1:0]  imem_addr1;
    logic [31:0] imem_data1, status1;
    logic [1:0]  mode1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];
    wr_t e0, e1;

    always #5 clk = ~clk;

    pkt_proc_ctrl dut0 (
        .clk(clk), .reset(reset), .pkt_wr(pkt_wr), .pkt_last(pkt_last),
        .fifo_full(fifo_full), .rx_rdy(rx_rdy0), .cmd_wr(cmd_wr), .cmd_data(cmd_data),
        .cmd_go(cmd_go), .cmd_clr(cmd_clr), .sw_reload(sw_reload), .imem_we(imem_we0),
        .imem_addr(imem_addr0), .imem_data(imem_data0), .proc_done(proc_done),
        .tx_done(tx_done), .timeout_cfg(timeout_cfg), .mode_code(mode0),
        .pipe_rst(pipe_rst0), .status(status0)
    );

    pkt_proc_ctrl #(.IMEM_AW(2)) dut1 (
        .clk(clk), .reset(reset), .pkt_wr(pkt_wr), .pkt_last(pkt_last),
        .fifo_full(fifo_full), .rx_rdy(rx_rdy1), .cmd_wr(cmd_wr), .cmd_data(cmd_data),
        .cmd_go(cmd_go), .cmd_clr(cmd_clr), .sw_reload(sw_reload), .imem_we(imem_we1),
        .imem_addr(imem_addr1), .imem_data(imem_data1), .proc_done(proc_done),
        .tx_done(tx_done), .timeout_cfg(timeout_cfg), .mode_code(mode1),
        .pipe_rst(pipe_rst1), .status(status1)
    );

    // Instruction-memory write monitors: every write must match the next expected entry.
    always @(negedge clk) begin
        if (imem_we0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL wr0_unexpected actual addr=%0h data=%h required no write", imem_addr0, imem_data0);
            end else begin
                e0 = q0.pop_front();
                if ({23'b0, imem_addr0} !== e0.addr || imem_data0 !== e0.data) begin
                    errors++;
                    $display("FAIL wr0 actual addr=%0h data=%h required addr=%0h data=%h",
                             imem_addr0, imem_data0, e0.addr, e0.data);
                end
            end
        end
        if (imem_we1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL wr1_unexpected actual addr=%0h data=%h required no write", imem_addr1, imem_data1);
            end else begin
                e1 = q1.pop_front();
                if ({30'b0, imem_addr1} !== e1.addr || imem_data1 !== e1.data) begin
                    errors++;
                    $display("FAIL wr1 actual addr=%0h data=%h required addr=%0h data=%h",
                             imem_addr1, imem_data1, e1.addr, e1.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] st(input int s, input int pv, input int ovf, input int drop,
                                       input int tmo, input int lc, input int pc);
        return {pc[15:0], lc[8:0], tmo[0], drop[0], ovf[0], pv[0], s[2:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int n);
        for (int i = 0; i < n; i++) begin
            pkt_wr   = 1'b1;
            pkt_last = (i == n - 1);
            tick();
        end
        pkt_wr   = 1'b0;
        pkt_last = 1'b0;
    endtask

    // One cmd_wr cycle; w0/w1 say whether each instance is expected to write it.
    task automatic do_cmd(input logic [31:0] d, input bit go, input bit w0, input int a0,
                          input bit w1, input int a1);
        wr_t w;
        cmd_wr   = 1'b1;
        cmd_data = d;
        cmd_go   = go;
        w.data   = d;
        if (w0) begin w.addr = a0; q0.push_back(w); end
        if (w1) begin w.addr = a1; q1.push_back(w); end
        tick();
        cmd_wr = 1'b0;
        cmd_go = 1'b0;
    endtask

    task automatic pulse(input int which);
        if (which == 0) proc_done = 1'b1; else tx_done = 1'b1;
        tick();
        proc_done = 1'b0;
        tx_done   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b0; pkt_wr = 0; pkt_last = 0; fifo_full = 0; cmd_wr = 0; cmd_go = 0;
        cmd_clr = 0; sw_reload = 0; proc_done = 0; tx_done = 0; cmd_data = '0; timeout_cfg = '0;
        tick(); tick();
        chk("rst_status", status0, 32'h0);
        chk("rst_mode", {30'b0, mode0}, 32'h0);
        chk("rst_pipe_rst", {31'b0, pipe_rst0}, 32'h1);
        chk("rst_rx_rdy", {31'b0, rx_rdy0}, 32'h0);
        chk("rst_imem", {imem_we0, imem_addr0, imem_data0[21:0]}, 32'h0);
        chk("rst_imem_data", imem_data0, 32'h0);
        reset = 1'b1;
        #1;
        chk("idle_status", status0, 32'h0);
        tick();
        chk("recv_status", status0, st(1, 0, 0, 0, 0, 0, 0));
        chk("recv_rx_rdy", {31'b0, rx_rdy0}, 32'h1);

        // 3-word packet with no program -> LOAD, then 4 writes with cmd_go on the last.
        send_pkt(3);
        chk("load_status", status0, st(2, 0, 0, 0, 0, 0, 0));
        chk("load_mode_pipe", {29'b0, mode0, pipe_rst0}, 32'h5);
        for (int i = 0; i < 4; i++)
            do_cmd(32'hA0 + i, i == 3, 1, i, 1, i);
        chk("prime_status0", status0, st(3, 1, 0, 0, 0, 4, 0));
        chk("prime_status1", status1, st(3, 1, 0, 0, 0, 4, 0));
        chk("prime_pipe_rst", {29'b0, mode0, pipe_rst0}, 32'h5);
        tick();
        chk("run_status", status0, st(4, 1, 0, 0, 0, 4, 0));
        chk("run_pipe_rst", {29'b0, mode0, pipe_rst0}, 32'h4);
        pulse(0);
        chk("send_status", status0, st(5, 1, 0, 0, 0, 4, 0));
        chk("send_mode", {30'b0, mode0}, 32'h1);
        pulse(1);
        chk("pkt1_status", status0, st(1, 1, 0, 0, 0, 4, 1));

        // Second packet with a valid program skips LOAD.
        send_pkt(1);
        chk("pkt2_prime", status0, st(3, 1, 0, 0, 0, 4, 1));
        tick();
        pulse(0);
        pulse(1);
        chk("pkt2_done", status0, st(1, 1, 0, 0, 0, 4, 2));

        // Backpressure and dropped command handling in RECV.
        fifo_full = 1'b1;
        #1;
        chk("full_rx_rdy", {31'b0, rx_rdy0}, 32'h0);
        send_pkt(3);
        chk("full_no_move", status0, st(1, 1, 0, 0, 0, 4, 2));
        do_cmd(32'hDEAD, 0, 0, 0, 0, 0);
        chk("cmd_drop_set", status0, st(1, 1, 0, 1, 0, 4, 2));
        cmd_clr = 1'b1;
        tick();
        cmd_clr = 1'b0;
        chk("cmd_drop_clr", status0, st(1, 1, 0, 0, 0, 4, 2));
        fifo_full = 1'b0;
        #1;
        chk("unfull_rx_rdy", {31'b0, rx_rdy0}, 32'h1);

        // Forced reload: 5 writes overflow the 4-entry instance only.
        sw_reload = 1'b1;
        send_pkt(1);
        sw_reload = 1'b0;
        chk("reload_status", status0, st(2, 1, 0, 0, 0, 0, 2));
        for (int i = 0; i < 5; i++)
            do_cmd(32'hB0 + i, 0, 1, i, i < 4, i);
        chk("ovf_status1", status1, st(2, 1, 1, 0, 0, 4, 2));
        chk("no_ovf_status0", status0, st(2, 1, 0, 0, 0, 5, 2));
        cmd_go = 1'b1;
        tick();
        cmd_go = 1'b0;
        tick();
        chk("run2_status", status0, st(4, 1, 0, 0, 0, 5, 2));

        // Reset mid-RUN takes effect without a clock edge.
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        chk("midrst_status", status0, 32'h0);
        chk("midrst_status1", status1, 32'h0);
        chk("midrst_outs", {mode0, pipe_rst0, rx_rdy0, imem_we0}, 32'h4);
        chk("midrst_imem", {imem_addr0, imem_data0[22:0]}, 32'h0);
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_idle", status0, 32'h0);
        tick();
        chk("midrst_recv", status0, st(1, 0, 0, 0, 0, 0, 0));

        // Watchdog: timeout_cfg=10 with no proc_done.
        timeout_cfg = 16'd10;
        send_pkt(1);
        chk("tmo_load", status0, st(2, 0, 0, 0, 0, 0, 0));
        do_cmd(32'hC0, 1, 1, 0, 1, 0);
        tick();
        chk("tmo_run_entry", status0, st(4, 1, 0, 0, 0, 1, 0));
        for (int i = 0; i < 9; i++) tick();
        chk("tmo_run_c10", status0, st(4, 1, 0, 0, 0, 1, 0));
        tick();
`ifdef PKT_PROC_CTRL_TIMEOUT_EN
        chk("tmo_err", status0, st(6, 1, 0, 0, 1, 1, 0));
        chk("tmo_err_outs", {mode0, pipe_rst0, rx_rdy0}, 32'h2);
        cmd_clr = 1'b1;
        tick();
        cmd_clr = 1'b0;
        chk("tmo_clr", status0, st(1, 0, 0, 0, 0, 1, 0));
`else
        chk("no_tmo_run", status0, st(4, 1, 0, 0, 0, 1, 0));
        for (int i = 0; i < 20; i++) tick();
        chk("no_tmo_run_late", status0, st(4, 1, 0, 0, 0, 1, 0));
`endif

        tick(); tick();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
